// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with write-back source select, $0 write suppression
// and a retired-instruction counter for the debug display path.
module mem_wb_stage #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RETIRE_W = 32,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                stall,
  input  logic                flush,
  input  logic                valid_mem,
  input  logic [DATA_W-1:0]   ALUResult_mem,
  input  logic [DATA_W-1:0]   MemDout_mem,
  input  logic [DATA_W-1:0]   PCPlus4_mem,
  input  logic                RegWrite_mem,
  input  logic                MemtoReg_mem,
  input  logic                Jal_mem,
  input  logic [4:0]          WriteReg_mem,
  output logic                valid_wb,
  output logic                RegWrite_wb,
  output logic [4:0]          WriteReg_wb,
  output logic [DATA_W-1:0]   WriteData_wb,
  output logic [RETIRE_W-1:0] retire_count
);

  localparam logic [RETIRE_W-1:0] CNT_MAX = '1;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_dout;
    logic [DATA_W-1:0] pc_plus4;
    logic              reg_write;
    logic              mem_to_reg;
    logic              jal;
    logic [4:0]        write_reg;
  } wb_reg_t;

  wb_reg_t             wb_q;
  logic [RETIRE_W-1:0] retire_q;
  logic                capture;

  assign capture = valid_mem & ~stall & ~flush;

  // Pipeline register: flush squashes only the qualifiers, stall holds everything
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wb_q <= '0;
    end else if (flush) begin
      wb_q.valid     <= 1'b0;
      wb_q.reg_write <= 1'b0;
    end else if (!stall) begin
      wb_q.valid      <= valid_mem;
      wb_q.alu_result <= ALUResult_mem;
      wb_q.mem_dout   <= MemDout_mem;
      wb_q.pc_plus4   <= PCPlus4_mem;
      wb_q.reg_write  <= RegWrite_mem;
      wb_q.mem_to_reg <= MemtoReg_mem;
      wb_q.jal        <= Jal_mem;
      wb_q.write_reg  <= WriteReg_mem;
    end
  end

  // One count per real instruction captured into WB
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retire_q <= '0;
    end else if (capture) begin
      if (retire_q == CNT_MAX) begin
        retire_q <= SATURATE ? CNT_MAX : '0;
      end else begin
        retire_q <= retire_q + RETIRE_W'(1);
      end
    end
  end

  // Write-back select decoded from registered state only
  always_comb begin
    WriteData_wb = wb_q.alu_result;
    if (wb_q.jal) begin
      WriteData_wb = wb_q.pc_plus4;
    end else if (wb_q.mem_to_reg) begin
      WriteData_wb = wb_q.mem_dout;
    end
  end

  assign valid_wb     = wb_q.valid;
  assign RegWrite_wb  = wb_q.reg_write & wb_q.valid & (wb_q.write_reg != 5'd0);
  assign WriteReg_wb  = wb_q.write_reg;
  assign retire_count = retire_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage, including 4-bit counter
// instances in saturating and wrapping modes.
module tb_mem_wb_stage;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        flush;
  logic        valid_mem;
  logic [31:0] alu;
  logic [31:0] mdout;
  logic [31:0] pc4;
  logic        rw;
  logic        m2r;
  logic        jal;
  logic [4:0]  wr;

  logic        valid_wb;
  logic        regwrite_wb;
  logic [4:0]  writereg_wb;
  logic [31:0] writedata_wb;
  logic [31:0] retire;

  logic        s_valid, s_rw, w_valid, w_rw;
  logic [4:0]  s_wr, w_wr;
  logic [31:0] s_wd, w_wd;
  logic [3:0]  s_cnt, w_cnt;

  int checks = 0;
  int errors = 0;

  mem_wb_stage #(.DATA_W(32), .RETIRE_W(32), .SATURATE(1'b1)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_mem(valid_mem),
    .ALUResult_mem(alu), .MemDout_mem(mdout), .PCPlus4_mem(pc4),
    .RegWrite_mem(rw), .MemtoReg_mem(m2r), .Jal_mem(jal), .WriteReg_mem(wr),
    .valid_wb(valid_wb), .RegWrite_wb(regwrite_wb), .WriteReg_wb(writereg_wb),
    .WriteData_wb(writedata_wb), .retire_count(retire)
  );

  mem_wb_stage #(.DATA_W(32), .RETIRE_W(4), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_mem(valid_mem),
    .ALUResult_mem(alu), .MemDout_mem(mdout), .PCPlus4_mem(pc4),
    .RegWrite_mem(rw), .MemtoReg_mem(m2r), .Jal_mem(jal), .WriteReg_mem(wr),
    .valid_wb(s_valid), .RegWrite_wb(s_rw), .WriteReg_wb(s_wr),
    .WriteData_wb(s_wd), .retire_count(s_cnt)
  );

  mem_wb_stage #(.DATA_W(32), .RETIRE_W(4), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .valid_mem(valid_mem),
    .ALUResult_mem(alu), .MemDout_mem(mdout), .PCPlus4_mem(pc4),
    .RegWrite_mem(rw), .MemtoReg_mem(m2r), .Jal_mem(jal), .WriteReg_mem(wr),
    .valid_wb(w_valid), .RegWrite_wb(w_rw), .WriteReg_wb(w_wr),
    .WriteData_wb(w_wd), .retire_count(w_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and settle
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_inputs();
    stall     = 1'($urandom);
    flush     = 1'($urandom);
    valid_mem = 1'($urandom);
    alu       = $urandom;
    mdout     = $urandom;
    pc4       = $urandom;
    rw        = 1'($urandom);
    m2r       = 1'($urandom);
    jal       = 1'($urandom);
    wr        = 5'($urandom);
  endtask

  initial begin
    reset = 1'b0;
    randomize_inputs();
    // Reset held with random activity
    for (int i = 0; i < 4; i++) begin
      cyc();
      randomize_inputs();
    end
    chk("rst_valid", 32'(valid_wb), 32'd0);
    chk("rst_regwrite", 32'(regwrite_wb), 32'd0);
    chk("rst_writereg", 32'(writereg_wb), 32'd0);
    chk("rst_writedata", writedata_wb, 32'd0);
    chk("rst_retire", retire, 32'd0);
    chk("rst_sat_cnt", 32'(s_cnt), 32'd0);

    // First instruction after release
    @(negedge clk);
    reset = 1'b1;
    stall = 0; flush = 0; valid_mem = 1;
    alu = 32'h1234; mdout = 32'h0; pc4 = 32'h0;
    rw = 1; m2r = 0; jal = 0; wr = 5'd8;
    cyc();
    chk("t1_writedata", writedata_wb, 32'h1234);
    chk("t1_regwrite", 32'(regwrite_wb), 32'd1);
    chk("t1_writereg", 32'(writereg_wb), 32'd8);
    chk("t1_valid", 32'(valid_wb), 32'd1);
    chk("t1_retire", retire, 32'd1);

    // Source select
    m2r = 1; mdout = 32'hDEAD0000; wr = 5'd9;
    cyc();
    chk("t2_memtoreg", writedata_wb, 32'hDEAD0000);
    chk("t2_retire", retire, 32'd2);
    jal = 1; pc4 = 32'h40;
    cyc();
    chk("t2_jal_over_mem", writedata_wb, 32'h40);
    chk("t2_retire_b", retire, 32'd3);

    // Write to $0 suppressed but still retired
    jal = 0; m2r = 0; alu = 32'h5555; wr = 5'd0; rw = 1;
    cyc();
    chk("t3_regwrite_r0", 32'(regwrite_wb), 32'd0);
    chk("t3_writereg_r0", 32'(writereg_wb), 32'd0);
    chk("t3_valid", 32'(valid_wb), 32'd1);
    chk("t3_writedata", writedata_wb, 32'h5555);
    chk("t3_retire", retire, 32'd4);

    // Stall holds everything
    alu = 32'hAAAA; wr = 5'd3; rw = 1;
    cyc();
    chk("t4_pre_stall", writedata_wb, 32'hAAAA);
    chk("t4_pre_retire", retire, 32'd5);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      alu = $urandom; mdout = $urandom; wr = 5'd7; m2r = 1'(i); rw = 0;
      cyc();
      chk("t4_stall_data", writedata_wb, 32'hAAAA);
      chk("t4_stall_wr", 32'(writereg_wb), 32'd3);
      chk("t4_stall_rw", 32'(regwrite_wb), 32'd1);
      chk("t4_stall_retire", retire, 32'd5);
    end
    // Flush beats stall
    flush = 1; m2r = 0;
    cyc();
    chk("t4_flush_valid", 32'(valid_wb), 32'd0);
    chk("t4_flush_rw", 32'(regwrite_wb), 32'd0);
    chk("t4_flush_retire", retire, 32'd5);
    chk("t4_flush_wr_kept", 32'(writereg_wb), 32'd3);
    // Bubble loads data but not validity
    stall = 0; flush = 0; valid_mem = 0; alu = 32'hBBBB; wr = 5'd4; rw = 1; m2r = 0; jal = 0;
    cyc();
    chk("t4_bubble_valid", 32'(valid_wb), 32'd0);
    chk("t4_bubble_rw", 32'(regwrite_wb), 32'd0);
    chk("t4_bubble_data", writedata_wb, 32'hBBBB);
    chk("t4_bubble_wr", 32'(writereg_wb), 32'd4);
    chk("t4_bubble_retire", retire, 32'd5);
    chk("t4_sat_cnt", 32'(s_cnt), 32'd5);
    chk("t4_wrap_cnt", 32'(w_cnt), 32'd5);

    // Narrow counters: saturate vs wrap over 17 captures
    reset = 0;
    #2;
    reset = 1;
    valid_mem = 1;
    for (int i = 1; i <= 17; i++) begin
      alu = 32'(i);
      cyc();
      if (i == 16) begin
        chk("t5_sat_16", 32'(s_cnt), 32'd15);
        chk("t5_wrap_16", 32'(w_cnt), 32'd0);
      end
    end
    chk("t5_sat_17", 32'(s_cnt), 32'd15);
    chk("t5_wrap_17", 32'(w_cnt), 32'd1);
    chk("t5_main_17", retire, 32'd17);

    // Async reset mid-stall clears before the next edge
    alu = 32'hCAFE; wr = 5'd5; rw = 1;
    cyc();
    chk("t6_pre", writedata_wb, 32'hCAFE);
    stall = 1;
    #2;
    reset = 0;
    #1;
    chk("t6_async_valid", 32'(valid_wb), 32'd0);
    chk("t6_async_rw", 32'(regwrite_wb), 32'd0);
    chk("t6_async_wr", 32'(writereg_wb), 32'd0);
    chk("t6_async_data", writedata_wb, 32'd0);
    chk("t6_async_retire", retire, 32'd0);
    #1;
    reset = 1;
    stall = 0; alu = 32'h7777; wr = 5'd6;
    cyc();
    chk("t6_after_data", writedata_wb, 32'h7777);
    chk("t6_after_rw", 32'(regwrite_wb), 32'd1);
    chk("t6_after_retire", retire, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
